// File: rtl/movimientos_pkg.sv
// movimientos_pkg
// Shared definitions for the 2048 move engine (motor_movimientos) and its
// line compressor (comprimir_linea).
//   TAM          board side length (4x4 board)
//   SEMILLA_DEF  default LFSR reset value (must be nonzero)
//   LFSR_TAPS    Fibonacci feedback mask for taps 16,14,13,11
//   dir_t        move direction: IZQ, DER, ARR, ABA
//   estado_t     move engine FSM states
//   linea_t      one board line, index 0 is the leading edge of the move
//   linea_movible() legality rule shared by the EVALUA check
package movimientos_pkg;

  localparam int TAM = 4;
  localparam logic [15:0] SEMILLA_DEF = 16'hACE1;
  // Bits 15,13,12,10 of the register correspond to taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IZQ = 2'd0,
    DER = 2'd1,
    ARR = 2'd2,
    ABA = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    LIMPIA,
    GENERA1,
    GENERA2,
    REPOSO,
    PROCESA,
    GENERA,
    EVALUA
  } estado_t;

  typedef int linea_t [TAM];

  // A line can move toward index 0 if a nonzero tile has an empty cell or an
  // equal tile directly ahead of it. Checking adjacent pairs is enough: any
  // zero ahead of a nonzero tile implies some adjacent (zero, nonzero) pair.
  function automatic logic linea_movible(input linea_t l);
    logic m;
    m = 1'b0;
    for (int k = 0; k < TAM - 1; k++) begin
      if (l[k+1] != 0 && (l[k] == 0 || l[k] == l[k+1])) begin
        m = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/comprimir_linea.sv
// comprimir_linea
// Purely combinational slide-and-merge of one 2048 line toward index 0.
// Ports:
//   linea_ent     in  linea_t : line before the move, index 0 = leading edge
//   linea_sal     out linea_t : line after sliding and merging
//   puntos        out int     : sum of the values produced by merges
//   linea_cambio  out 1       : 1 when linea_sal differs from linea_ent
module comprimir_linea
  import movimientos_pkg::*;
(
  input  linea_t linea_ent,
  output linea_t linea_sal,
  output int     puntos,
  output logic   linea_cambio
);

  // One spare zero slot at the end lets the merge pass look at i+1 for the
  // last tile without a special case; zero never merges.
  int         compacta [TAM+1];
  logic [1:0] n;
  logic [1:0] k;
  logic       saltar;

  // First squeeze out the zeros, then merge equal neighbours from the leading
  // edge. A merged result is emitted directly and its partner is skipped, so
  // the new tile can never take part in a second merge in the same move.
  always_comb begin
    compacta = '{default: 0};
    n = 2'd0;
    for (int i = 0; i < TAM; i++) begin
      if (linea_ent[i] != 0) begin
        compacta[{1'b0, n}] = linea_ent[i];
        n = n + 2'd1;
      end
    end

    linea_sal = '{default: 0};
    puntos = 0;
    k = 2'd0;
    saltar = 1'b0;
    for (int i = 0; i < TAM; i++) begin
      if (saltar) begin
        saltar = 1'b0;
      end else if (compacta[i] != 0) begin
        if (compacta[i] == compacta[i+1]) begin
          linea_sal[k] = compacta[i] * 2;
          puntos = puntos + compacta[i] * 2;
          saltar = 1'b1;
        end else begin
          linea_sal[k] = compacta[i];
        end
        k = k + 2'd1;
      end
    end

    linea_cambio = 1'b0;
    for (int i = 0; i < TAM; i++) begin
      if (linea_sal[i] != linea_ent[i]) begin
        linea_cambio = 1'b1;
      end
    end
  end

endmodule

// File: rtl/motor_movimientos.sv
// motor_movimientos
// Sequential move engine for the 4x4 2048 board: processes one line per
// cycle, spawns a pseudo-random tile after a changing move and recomputes
// the legal directions for the downstream win/lose checker.
// Parameters:
//   SEMILLA        LFSR reset value (nonzero)
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   dir_valida     move request, sampled while listo=1
//   dir            0 izq, 1 der, 2 arr, 3 aba
//   carga_valida   load request (wins over dir_valida), sampled while listo=1
//   matriz_carga   board to load, [fila][columna]
//   listo          idle and ready for a command
//   cambio         one-cycle pulse when the last move altered the board
//   matriz_salida  registered board, [fila][columna], 0 = empty
//   mov_izq/der/arr/aba  1 if that direction would change the board
//   puntaje        accumulated score
// Build option:
//   MOVIMIENTOS_PUNTAJE_EN  defined: score accumulator built;
//                           undefined: puntaje tied to 0.
module motor_movimientos
  import movimientos_pkg::*;
#(
  parameter logic [15:0] SEMILLA = SEMILLA_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dir_valida,
  input  logic [1:0] dir,
  input  logic       carga_valida,
  input  int         matriz_carga [TAM][TAM],
  output logic       listo,
  output logic       cambio,
  output int         matriz_salida [TAM][TAM],
  output int         mov_izq,
  output int         mov_der,
  output int         mov_arr,
  output int         mov_aba,
  output int         puntaje
);

  estado_t     estado;
  estado_t     estado_sig;
  int          tablero [TAM][TAM];
  logic [15:0] lfsr;
  logic [15:0] lfsr_sig;
  dir_t        dir_reg;
  logic [1:0]  contador;
  logic        hubo_cambio;
  logic [3:0]  mov_reg;

  linea_t      linea_ent;
  linea_t      linea_sal;
  int          puntos_linea;
  logic        linea_cambio;
  logic [1:0]  fila_map [TAM];
  logic [1:0]  col_map [TAM];

  logic        hay_vacia;
  logic [3:0]  pos_vacia;
  logic [3:0]  idx;
  int          valor_nuevo;

  linea_t      fila_ida;
  linea_t      fila_vuelta;
  linea_t      col_ida;
  linea_t      col_vuelta;
  logic        mov_calc_izq;
  logic        mov_calc_der;
  logic        mov_calc_arr;
  logic        mov_calc_aba;

  assign lfsr_sig = {lfsr[14:0], ^(lfsr & LFSR_TAPS)};

  // Map position k of the line being processed to a board cell. Reversed
  // directions use ~k (3-k) so the compressor always slides toward index 0,
  // and the same map is used again to write the result back.
  always_comb begin
    fila_map = '{default: 2'd0};
    col_map = '{default: 2'd0};
    linea_ent = '{default: 0};
    for (int k = 0; k < TAM; k++) begin
      case (dir_reg)
        IZQ: begin
          fila_map[k] = contador;
          col_map[k] = 2'(k);
        end
        DER: begin
          fila_map[k] = contador;
          col_map[k] = ~(2'(k));
        end
        ARR: begin
          fila_map[k] = 2'(k);
          col_map[k] = contador;
        end
        default: begin
          fila_map[k] = ~(2'(k));
          col_map[k] = contador;
        end
      endcase
      linea_ent[k] = tablero[fila_map[k]][col_map[k]];
    end
  end

  comprimir_linea u_comprimir (
    .linea_ent    (linea_ent),
    .linea_sal    (linea_sal),
    .puntos       (puntos_linea),
    .linea_cambio (linea_cambio)
  );

  // Spawn cell: first empty row-major index at or after lfsr[3:0], wrapping.
  // Scanning offsets from far to near lets the nearest empty cell win.
  always_comb begin
    hay_vacia = 1'b0;
    pos_vacia = lfsr[3:0];
    idx = 4'd0;
    for (int j = TAM * TAM - 1; j >= 0; j--) begin
      idx = lfsr[3:0] + 4'(j);
      if (tablero[idx[3:2]][idx[1:0]] == 0) begin
        hay_vacia = 1'b1;
        pos_vacia = idx;
      end
    end
    valor_nuevo = (lfsr[7:4] == 4'd0) ? 4 : 2;
  end

  // Legality of every direction from the current board, evaluated by viewing
  // each row/column in the orientation that direction slides toward.
  always_comb begin
    fila_ida = '{default: 0};
    fila_vuelta = '{default: 0};
    col_ida = '{default: 0};
    col_vuelta = '{default: 0};
    mov_calc_izq = 1'b0;
    mov_calc_der = 1'b0;
    mov_calc_arr = 1'b0;
    mov_calc_aba = 1'b0;
    for (int i = 0; i < TAM; i++) begin
      for (int k = 0; k < TAM; k++) begin
        fila_ida[k] = tablero[i][k];
        fila_vuelta[k] = tablero[i][~(2'(k))];
        col_ida[k] = tablero[k][i];
        col_vuelta[k] = tablero[~(2'(k))][i];
      end
      mov_calc_izq = mov_calc_izq | linea_movible(fila_ida);
      mov_calc_der = mov_calc_der | linea_movible(fila_vuelta);
      mov_calc_arr = mov_calc_arr | linea_movible(col_ida);
      mov_calc_aba = mov_calc_aba | linea_movible(col_vuelta);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= LIMPIA;
    end else begin
      estado <= estado_sig;
    end
  end

  // Next state and listo. A load always wins over a simultaneous move.
  always_comb begin
    estado_sig = estado;
    listo = 1'b0;
    case (estado)
      LIMPIA:  estado_sig = GENERA1;
      GENERA1: estado_sig = GENERA2;
      GENERA2: estado_sig = EVALUA;
      REPOSO: begin
        listo = 1'b1;
        if (carga_valida) begin
          estado_sig = EVALUA;
        end else if (dir_valida) begin
          estado_sig = PROCESA;
        end
      end
      PROCESA: begin
        if (contador == 2'd3) begin
          estado_sig = GENERA;
        end
      end
      GENERA:  estado_sig = EVALUA;
      EVALUA:  estado_sig = REPOSO;
      default: estado_sig = LIMPIA;
    endcase
  end

  // Board, LFSR and move bookkeeping. The LFSR free-runs in every state;
  // hubo_cambio is the sticky "some line changed" flag for the current move
  // and is cleared on every accepted command so loads never pulse cambio.
  always_ff @(posedge clk) begin
    if (rst) begin
      tablero <= '{default: 0};
      lfsr <= SEMILLA;
      dir_reg <= IZQ;
      contador <= 2'd0;
      hubo_cambio <= 1'b0;
      mov_reg <= 4'b1111;
      cambio <= 1'b0;
    end else begin
      lfsr <= lfsr_sig;
      cambio <= 1'b0;
      case (estado)
        LIMPIA: begin
          tablero <= '{default: 0};
          hubo_cambio <= 1'b0;
        end
        GENERA1, GENERA2: begin
          if (hay_vacia) begin
            tablero[pos_vacia[3:2]][pos_vacia[1:0]] <= valor_nuevo;
          end
        end
        REPOSO: begin
          if (carga_valida) begin
            tablero <= matriz_carga;
            hubo_cambio <= 1'b0;
          end else if (dir_valida) begin
            dir_reg <= dir_t'(dir);
            contador <= 2'd0;
            hubo_cambio <= 1'b0;
          end
        end
        PROCESA: begin
          for (int k = 0; k < TAM; k++) begin
            tablero[fila_map[k]][col_map[k]] <= linea_sal[k];
          end
          hubo_cambio <= hubo_cambio | linea_cambio;
          contador <= contador + 2'd1;
        end
        GENERA: begin
          if (hubo_cambio && hay_vacia) begin
            tablero[pos_vacia[3:2]][pos_vacia[1:0]] <= valor_nuevo;
          end
        end
        EVALUA: begin
          mov_reg <= {mov_calc_aba, mov_calc_arr, mov_calc_der, mov_calc_izq};
          cambio <= hubo_cambio;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MOVIMIENTOS_PUNTAJE_EN
  int puntaje_acum;

  // Score grows by the merge sum of each processed line; loads leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      puntaje_acum <= 0;
    end else if (estado == PROCESA) begin
      puntaje_acum <= puntaje_acum + puntos_linea;
    end
  end

  assign puntaje = puntaje_acum;
`else
  logic puntos_unused;
  assign puntos_unused = |puntos_linea;
  assign puntaje = 0;
`endif

  assign matriz_salida = tablero;
  assign mov_izq = {31'd0, mov_reg[0]};
  assign mov_der = {31'd0, mov_reg[1]};
  assign mov_arr = {31'd0, mov_reg[2]};
  assign mov_aba = {31'd0, mov_reg[3]};

endmodule

// File: tb/tb_motor_movimientos.sv
// tb_motor_movimientos
// Self-checking bench for motor_movimientos: directed board scenarios plus
// randomized loads and moves, compared against a queue-based 2048 model.
// Honors MOVIMIENTOS_PUNTAJE_EN for the expected score.
module tb_motor_movimientos;

  typedef int tab_t [4][4];

`ifdef MOVIMIENTOS_PUNTAJE_EN
  localparam bit PUNTAJE_EN = 1'b1;
`else
  localparam bit PUNTAJE_EN = 1'b0;
`endif
  localparam logic [15:0] SEMILLA = 16'hACE1;
  localparam int LIMITE = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dir_valida = 1'b0;
  logic [1:0] dir = 2'd0;
  logic       carga_valida = 1'b0;
  tab_t       matriz_carga;
  logic       listo;
  logic       cambio;
  tab_t       matriz_salida;
  int         mov_izq;
  int         mov_der;
  int         mov_arr;
  int         mov_aba;
  int         puntaje;

  int          n_checks;
  int          n_fail;
  tab_t        m_tab;
  int          m_puntaje;
  logic [15:0] m_lfsr;

  motor_movimientos #(.SEMILLA(SEMILLA)) dut (
    .clk           (clk),
    .rst           (rst),
    .dir_valida    (dir_valida),
    .dir           (dir),
    .carga_valida  (carga_valida),
    .matriz_carga  (matriz_carga),
    .listo         (listo),
    .cambio        (cambio),
    .matriz_salida (matriz_salida),
    .mov_izq       (mov_izq),
    .mov_der       (mov_der),
    .mov_arr       (mov_arr),
    .mov_aba       (mov_aba),
    .puntaje       (puntaje)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] paso_lfsr(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Reference LFSR, stepped once per clock like the engine's generator.
  always @(posedge clk) begin
    if (rst) m_lfsr = SEMILLA;
    else m_lfsr = paso_lfsr(m_lfsr);
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fila_de(input int d, input int i, input int k);
    case (d)
      0, 1:    return i;
      2:       return k;
      default: return 3 - k;
    endcase
  endfunction

  function automatic int col_de(input int d, input int i, input int k);
    case (d)
      0:       return k;
      1:       return 3 - k;
      default: return i;
    endcase
  endfunction

  // 2048 move model: pull nonzero tiles into a queue and pair them greedily
  // from the front; each pair produces one merged tile.
  task automatic mover(input tab_t b, input int d, output tab_t r, output int pts, output bit chg);
    int q[$];
    int res[$];
    int a;
    r = b;
    pts = 0;
    chg = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q.delete();
      res.delete();
      for (int k = 0; k < 4; k++) begin
        if (b[fila_de(d, i, k)][col_de(d, i, k)] != 0) q.push_back(b[fila_de(d, i, k)][col_de(d, i, k)]);
      end
      while (q.size() > 0) begin
        a = q.pop_front();
        if (q.size() > 0) begin
          if (q[0] == a) begin
            a = a * 2;
            pts += a;
            void'(q.pop_front());
          end
        end
        res.push_back(a);
      end
      while (res.size() < 4) res.push_back(0);
      for (int k = 0; k < 4; k++) begin
        if (r[fila_de(d, i, k)][col_de(d, i, k)] != res[k]) chg = 1'b1;
        r[fila_de(d, i, k)][col_de(d, i, k)] = res[k];
      end
    end
  endtask

  // New tile goes to the first empty cell (row-major) whose index is at
  // least lf[3:0], otherwise to the lowest empty cell.
  task automatic spawn(inout tab_t b, input logic [15:0] lf);
    int libres[$];
    int elegido;
    bit hallado;
    for (int p = 0; p < 16; p++) if (b[p / 4][p % 4] == 0) libres.push_back(p);
    if (libres.size() > 0) begin
      elegido = libres[0];
      hallado = 1'b0;
      foreach (libres[j]) begin
        if (!hallado && libres[j] >= int'(lf[3:0])) begin
          elegido = libres[j];
          hallado = 1'b1;
        end
      end
      b[elegido / 4][elegido % 4] = (lf[7:4] == 4'd0) ? 4 : 2;
    end
  endtask

  function automatic int diferencias(input tab_t a, input tab_t b);
    int n = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (a[i][j] != b[i][j]) n++;
    return n;
  endfunction

  function automatic int no_ceros(input tab_t a);
    int n = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (a[i][j] != 0) n++;
    return n;
  endfunction

  task automatic checkEstado(input string tag);
    tab_t tmp;
    int   pts;
    bit   chg;
    int   movs [4];
    movs = '{mov_izq, mov_der, mov_arr, mov_aba};
    checkOutput({tag, "/board_cells_wrong"}, diferencias(matriz_salida, m_tab), 0);
    for (int d = 0; d < 4; d++) begin
      mover(m_tab, d, tmp, pts, chg);
      checkOutput($sformatf("%s/mov%0d", tag, d), movs[d], int'(chg));
    end
    checkOutput({tag, "/puntaje"}, puntaje, PUNTAJE_EN ? m_puntaje : 0);
  endtask

  task automatic chequeoReset(input string tag);
    checkOutput({tag, "/nonzero"}, no_ceros(matriz_salida), 0);
    checkOutput({tag, "/mov_izq"}, mov_izq, 1);
    checkOutput({tag, "/mov_der"}, mov_der, 1);
    checkOutput({tag, "/mov_arr"}, mov_arr, 1);
    checkOutput({tag, "/mov_aba"}, mov_aba, 1);
    checkOutput({tag, "/puntaje"}, puntaje, 0);
    checkOutput({tag, "/listo"}, int'(listo), 0);
    checkOutput({tag, "/cambio"}, int'(cambio), 0);
  endtask

  // Called with rst held high; releases it and follows the start-up tiles.
  task automatic arranque(input string tag);
    int          ciclos;
    logic [15:0] lf1;
    logic [15:0] lf2;
    bit          fin;
    @(negedge clk);
    rst = 1'b0;
    ciclos = 0;
    lf1 = 16'd0;
    lf2 = 16'd0;
    fin = 1'b0;
    while (!fin) begin
      @(posedge clk);
      ciclos++;
      @(negedge clk);
      if (ciclos == 1) lf1 = m_lfsr;
      if (ciclos == 2) lf2 = m_lfsr;
      if (listo || ciclos >= LIMITE) fin = 1'b1;
    end
    m_tab = '{default: 0};
    spawn(m_tab, lf1);
    spawn(m_tab, lf2);
    m_puntaje = 0;
    checkOutput({tag, "/latency"}, ciclos, 4);
    checkOutput({tag, "/two_tiles"}, no_ceros(matriz_salida), 2);
    checkOutput({tag, "/cambio"}, int'(cambio), 0);
    checkEstado(tag);
  endtask

  // One command from REPOSO. Latency counts edges from the accepting edge up
  // to the first edge after which listo is high. Optionally pulses dir_valida
  // while the engine is busy; that pulse must be ignored.
  task automatic applyStimulus(input bit es_carga, input tab_t carga, input int d,
                               input bit pulso_ocupado, input string tag);
    tab_t        esperado;
    int          pts;
    bit          chg;
    int          ciclos;
    int          lat;
    logic [15:0] lf_gen;
    bit          fin;
    @(negedge clk);
    checkOutput({tag, "/listo_before"}, int'(listo), 1);
    if (es_carga) begin
      matriz_carga = carga;
      carga_valida = 1'b1;
    end else begin
      dir = 2'(d);
      dir_valida = 1'b1;
    end
    @(posedge clk);
    ciclos = 1;
    lf_gen = 16'd0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      carga_valida = 1'b0;
      dir_valida = pulso_ocupado && ciclos == 1;
      dir = 2'(d ^ 1);
      if (ciclos == 5) lf_gen = m_lfsr;
      if (listo || ciclos >= LIMITE) begin
        fin = 1'b1;
      end else begin
        @(posedge clk);
        ciclos++;
      end
    end
    dir_valida = 1'b0;
    if (es_carga) begin
      m_tab = carga;
      chg = 1'b0;
      lat = 2;
    end else begin
      mover(m_tab, d, esperado, pts, chg);
      m_tab = esperado;
      m_puntaje += pts;
      if (chg) spawn(m_tab, lf_gen);
      lat = 7;
    end
    checkOutput({tag, "/latency"}, ciclos, lat);
    checkOutput({tag, "/cambio"}, int'(cambio), int'(chg));
    checkEstado(tag);
  endtask

  initial begin
    tab_t vacio;
    tab_t b;
    n_checks = 0;
    n_fail = 0;
    m_puntaje = 0;
    vacio = '{default: 0};
    matriz_carga = vacio;
    m_tab = vacio;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chequeoReset("reset");
    arranque("startup");

    // [2,2,2,2] slides left to [4,4,0,0] with one new tile.
    b = vacio;
    b[0] = '{2, 2, 2, 2};
    applyStimulus(1'b1, b, 0, 1'b0, "load_2222");
    applyStimulus(1'b0, vacio, 0, 1'b0, "izq_2222");
    checkOutput("izq_2222/r0c0", matriz_salida[0][0], 4);
    checkOutput("izq_2222/r0c1", matriz_salida[0][1], 4);
    checkOutput("izq_2222/tiles", no_ceros(matriz_salida), 3);

    // [2,2,4,0]: the fresh 4 must not merge with the existing 4.
    b = vacio;
    b[0] = '{2, 2, 4, 0};
    applyStimulus(1'b1, b, 0, 1'b0, "load_2240");
    applyStimulus(1'b0, vacio, 0, 1'b0, "izq_2240");
    checkOutput("izq_2240/r0c0", matriz_salida[0][0], 4);
    checkOutput("izq_2240/r0c1", matriz_salida[0][1], 4);

    // Column 0 = [0,0,2,2] moved up, then the same column moved down.
    b = vacio;
    b[2][0] = 2;
    b[3][0] = 2;
    applyStimulus(1'b1, b, 0, 1'b0, "load_col");
    applyStimulus(1'b0, vacio, 2, 1'b0, "arr_col");
    checkOutput("arr_col/r0c0", matriz_salida[0][0], 4);
    applyStimulus(1'b1, b, 0, 1'b0, "reload_col");
    applyStimulus(1'b0, vacio, 3, 1'b0, "aba_col");
    checkOutput("aba_col/r3c0", matriz_salida[3][0], 4);

    // [2,4,0,0] cannot move left: nothing changes, nothing spawns.
    b = vacio;
    b[0] = '{2, 4, 0, 0};
    applyStimulus(1'b1, b, 0, 1'b0, "load_2400");
    applyStimulus(1'b0, vacio, 0, 1'b0, "izq_2400");
    checkOutput("izq_2400/tiles", no_ceros(matriz_salida), 2);
    checkOutput("izq_2400/mov_izq", mov_izq, 0);
    checkOutput("izq_2400/mov_der", mov_der, 1);
    checkOutput("izq_2400/mov_arr", mov_arr, 0);
    checkOutput("izq_2400/mov_aba", mov_aba, 1);

    // Dead checkerboard; a busy-time move pulse must be ignored.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        b[i][j] = ((i + j) % 2 == 0) ? 2 : 4;
    applyStimulus(1'b1, b, 1, 1'b1, "load_checker");
    checkOutput("load_checker/mov_sum", mov_izq + mov_der + mov_arr + mov_aba, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("checker_idle/cells_changed", diferencias(matriz_salida, b), 0);
    checkOutput("checker_idle/listo", int'(listo), 1);
    applyStimulus(1'b0, vacio, 0, 1'b0, "izq_checker");

    // Randomized loads and moves, with occasional busy-time pulses.
    applyStimulus(1'b1, vacio, 0, 1'b0, "load_empty");
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            case ($urandom_range(0, 7))
              0, 1, 2, 3: b[i][j] = 0;
              4, 5:       b[i][j] = 2;
              6:          b[i][j] = 4;
              default:    b[i][j] = 8;
            endcase
          end
        end
        applyStimulus(1'b1, b, 0, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_load", it));
      end else begin
        applyStimulus(1'b0, vacio, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $sformatf("rnd%0d_move", it));
      end
    end

    // Reset in the middle of PROCESA.
    b = vacio;
    b[1] = '{2, 2, 8, 8};
    applyStimulus(1'b1, b, 0, 1'b0, "load_pre_rst");
    @(negedge clk);
    dir = 2'd0;
    dir_valida = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dir_valida = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chequeoReset("rst_in_procesa");
    arranque("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_movimientos.md
# motor_movimientos

Sequential move engine for the 4x4 2048 board. It accepts one direction command at a time and slides/merges the board line by line. It then spawns a new tile in a pseudo-random empty cell and recomputes which of the four directions are still legal. It sits directly upstream of the win/lose checker: `matriz_salida` and `mov_*` feed that checker, and the checker's `gano`/`perdio` go to the game FSM.

## Interface
- `SEMILLA`, default 16'hACE1: LFSR reset value. Must be nonzero.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `dir_valida` in 1: move request; sampled only while `listo`=1.
- `dir` in 2: 0 izq, 1 der, 2 arr, 3 aba.
- `carga_valida` in 1: load board from `matriz_carga`; sampled only while `listo`=1.
- `matriz_carga` in int[4][4]: board to load.
- `listo` out 1: idle, ready for a command.
- `cambio` out 1: one-cycle pulse when a move altered the board.
- `matriz_salida` out int[4][4]: current board; [fila][columna], 0 = empty.
- `mov_izq`, `mov_der`, `mov_arr`, `mov_aba` out int: 1 if that direction would change the board, else 0.
- `puntaje` out int: accumulated score.

## Operation
- FSM states: LIMPIA, GENERA1, GENERA2, REPOSO, PROCESA, GENERA, EVALUA.
- Reset: board 0, `puntaje` 0, `mov_*` 1 (no spurious loss), `listo` 0, `cambio` 0, LFSR = `SEMILLA`, state LIMPIA.
- Start-up path: LIMPIA → GENERA1 → GENERA2 → EVALUA → REPOSO. This places two tiles.
- REPOSO, `listo`=1. Command priority: `carga_valida` over `dir_valida`.
  - Load: the board is replaced and `puntaje` is untouched, then → EVALUA.
  - Move: the direction is latched, line counter = 0, then → PROCESA.
- PROCESA, one line per cycle for lines 0..3:
  - izq: row i, left-to-right.
  - der: row i, reversed.
  - arr: column i, top-to-bottom.
  - aba: column i, reversed.
  - Each line is slid toward index 0 and merged, then written back through the same mapping.
- Merge rules:
  - Equal adjacent nonzero tiles merge once per move, leading edge first.
  - A freshly merged tile does not merge again in the same move.
  - `puntaje` += the sum of merged values.
- A sticky flag records whether any line changed.
- GENERA, entered after line 3:
  - If the flag is set, place one tile. The cell is the first empty cell at or after row-major index `lfsr[3:0]`, wrapping around.
  - The tile value is 4 if `lfsr[7:4]`==0, else 2.
  - If the flag is clear, the board is untouched.
- EVALUA: all four `mov_*` are recomputed from the current board in one cycle. A direction is legal if any line in that direction has:
  - a zero ahead of a nonzero tile, or
  - two adjacent equal nonzero tiles.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle in every state.
- Arithmetic: int values with no saturation; 131072 is the maximum reachable tile.
- Commands received while `listo`=0 are ignored; there is no queuing.
- `rst` in any state aborts the operation and restores the reset values on the next edge.

## Timing
- Move accepted at edge T:
  - PROCESA occupies T+1..T+4.
  - GENERA is at T+5; the new board is visible after the T+5 edge.
  - EVALUA is at T+6; `mov_*` are valid after the T+6 edge.
  - `listo`=1 and `cambio` pulse are asserted in the cycle after T+6.
  - Latency is 7 cycles, fixed whether or not the board changed.
- Load accepted at T: EVALUA at T+1, `listo` at T+2.
- After `rst` deasserts: `listo` rises 4 cycles later.
- `matriz_salida` is registered and changes only on edges in PROCESA, GENERA, GENERA1, GENERA2, LIMPIA, or on a load.
- `dir_valida` and `carga_valida` need to be held for only the one cycle in which `listo`=1.

## Configuration
- `MOVIMIENTOS_PUNTAJE_EN` defined: the score accumulator is built and `puntaje` behaves as above.
- `MOVIMIENTOS_PUNTAJE_EN` undefined: there is no accumulator and `puntaje` is constant 0. All other behaviour and timing are identical.

## Structure
- `movimientos_pkg` holds:
  - `dir_t` enum (IZQ, DER, ARR, ABA);
  - `estado_t` enum;
  - `TAM`=4;
  - LFSR taps;
  - `SEMILLA_DEF`.
- Sub-module `comprimir_linea`, purely combinational:
  - Input: int[4] line.
  - Outputs: int[4] line, int puntos, 1-bit `linea_cambio`.
  - PROCESA instantiates one copy.
- The legality check in EVALUA lives in the top module and reuses the same adjacency rules.

## Test plan
- Load row0=[2,2,2,2], rest 0, then izq → row0=[4,4,0,0], `puntaje` +8, `cambio`=1, one new tile placed, `listo` 7 cycles after accept.
- Load row0=[2,2,4,0] then izq → [4,4,0,0], `puntaje` +4 (no cascade merge).
- Load column0=[0,0,2,2] top-to-bottom then arr → column0=[4,0,0,0]. Load the same column then aba → [0,0,0,4].
- Load row0=[2,4,0,0], rest 0, then izq → board unchanged, `cambio`=0, no tile spawned, `mov_izq`=0, `mov_der`=1, `mov_arr`=0, `mov_aba`=1.
- Load a full checkerboard of 2/4 with no equal neighbours → all `mov_*`=0 two cycles after load. A `dir_valida` pulse while `listo`=0 → ignored.
- `rst` during PROCESA → next cycle board all 0, `mov_*`=1, `puntaje`=0. With `SEMILLA`=16'hACE1, `listo`=1 after 4 cycles with exactly two nonzero tiles.
